// File: rtl/smc_pkg.sv
// Shared constants for the smc_stream slice: FSM encodings plus width and divisor helpers.
package smc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Divisor of the weighted average: sum of weights K..2K-1.
  function automatic int weight_div(input int k);
    return k * k + (k * (k - 1)) / 2;
  endfunction

  // Bits needed for k*(2k-1)*(2^mw-1), the worst-case weighted sum.
  function automatic int sum_width(input int k, input int mw);
    return $clog2(k * (2 * k - 1)) + mw;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/smc_stream_if.sv
// Beat input / result output bundle for smc_stream; master = front-end + sink, slave = block.
// With SMC_REGION_CNT_EN defined it also carries sat_cnt.
interface smc_stream_if #(
  parameter int VW = 3
`ifdef SMC_REGION_CNT_EN
  , parameter int N_MOS = 6
`endif
);
  import smc_pkg::*;

  localparam int MW = 3 * VW;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [VW-1:0] w;
  logic [VW-1:0] v_gs;
  logic [VW-1:0] v_ds;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_n;
`ifdef SMC_REGION_CNT_EN
  logic [cnt_width(N_MOS)-1:0] sat_cnt;

  modport master (output in_valid, mode, w, v_gs, v_ds, out_ready,
                  input  in_ready, out_valid, out_n, sat_cnt);
  modport slave  (input  in_valid, mode, w, v_gs, v_ds, out_ready,
                  output in_ready, out_valid, out_n, sat_cnt);
`else
  modport master (output in_valid, mode, w, v_gs, v_ds, out_ready,
                  input  in_ready, out_valid, out_n);
  modport slave  (input  in_valid, mode, w, v_gs, v_ds, out_ready,
                  output in_ready, out_valid, out_n);
`endif

endinterface

// File: rtl/smc_metric.sv
// Per-beat MOSFET metric: Id (mode0=1) or gm (mode0=0), floor-divided by 3.
// Latency: combinational. Backpressure: none; sat output exists only with SMC_REGION_CNT_EN.
module smc_metric #(
  parameter int VW = 3
) (
  input  logic [VW-1:0]   w,
  input  logic [VW-1:0]   v_gs,
  input  logic [VW-1:0]   v_ds,
  input  logic            mode0,
`ifdef SMC_REGION_CNT_EN
  output logic            sat,
`endif
  output logic [3*VW-1:0] metric
);

  localparam int MW = 3 * VW;
  localparam int IW = 3 * VW + 2;

  logic [VW-1:0] vov;
  logic          triode;
  logic [IW-1:0] w_x, vds_x, vov_x, prod;

  assign vov    = (v_gs == '0) ? '0 : v_gs - VW'(1);
  assign triode = vov > v_ds;
  assign w_x    = IW'(w);
  assign vds_x  = IW'(v_ds);
  assign vov_x  = IW'(vov);

  // 2*vov - v_ds is strictly positive whenever the triode branch is taken.
  always_comb begin
    prod = '0;
    if (mode0)
      prod = triode ? w_x * vds_x * ((vov_x << 1) - vds_x) : w_x * vov_x * vov_x;
    else
      prod = triode ? (w_x * vds_x) << 1 : (w_x * vov_x) << 1;
  end

  assign metric = MW'(prod / IW'(3));

`ifdef SMC_REGION_CNT_EN
  assign sat = !triode;
`endif

endmodule

// File: rtl/smc_stream.sv
// Frame of N_MOS descriptors -> plain/weighted average of the K_SEL largest/smallest metrics.
// Latency: out_valid in the 2nd cycle after the last accepted beat; in_ready low in CALC/OUT.
// Result held until out_ready. SMC_REGION_CNT_EN adds sat_cnt (saturation beats in frame).
module smc_stream import smc_pkg::*; #(
  parameter int N_MOS = 6,
  parameter int K_SEL = 3,
  parameter int VW    = 3
) (
  input logic       clk,
  input logic       rst,
  smc_stream_if.slave bus
);

  localparam int MW    = 3 * VW;
  localparam int SW    = sum_width(K_SEL, MW);
  localparam int DIV_W = weight_div(K_SEL);
  localparam int CTW   = $clog2(N_MOS);

  logic [1:0]     state;
  logic [CTW-1:0] cnt;
  logic [1:0]     mode_q;
  logic [MW-1:0]  out_q;
  logic [MW-1:0]  arr [N_MOS];
  logic [MW-1:0]  ins [N_MOS];
  logic [MW-1:0]  metric;
  logic [MW-1:0]  sel;
  logic [SW-1:0]  sum, quot;
  logic           mode0, accept;

  assign bus.in_ready  = !rst && (state == ST_IDLE || state == ST_LOAD);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_n     = out_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign mode0         = (state == ST_IDLE) ? bus.mode[0] : mode_q[0];

`ifdef SMC_REGION_CNT_EN
  localparam int CW = cnt_width(N_MOS);
  logic          sat;
  logic [CW-1:0] sat_acc, sat_q;
  assign bus.sat_cnt = sat_q;

  smc_metric #(.VW(VW)) u_metric (
    .w(bus.w), .v_gs(bus.v_gs), .v_ds(bus.v_ds), .mode0(mode0), .sat(sat), .metric(metric)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_acc <= '0;
      sat_q   <= '0;
    end else begin
      if (accept)
        sat_acc <= (state == ST_IDLE) ? CW'(sat) : sat_acc + CW'(sat);
      if (state == ST_CALC)
        sat_q <= sat_acc;
    end
  end
`else
  smc_metric #(.VW(VW)) u_metric (
    .w(bus.w), .v_gs(bus.v_gs), .v_ds(bus.v_ds), .mode0(mode0), .metric(metric)
  );
`endif

  // Single-cycle sorted insert; the smallest entry falls off the bottom. Cleared
  // slots hold 0, so after N_MOS inserts only real metrics remain.
  for (genvar g = 0; g < N_MOS; g++) begin : g_ins
    logic          above_ge;
    logic [MW-1:0] above;
    if (g == 0) begin : g_top
      assign above_ge = 1'b1;
      assign above    = '0;
    end else begin : g_rest
      assign above_ge = arr[g-1] >= metric;
      assign above    = arr[g-1];
    end
    assign ins[g] = (arr[g] >= metric) ? arr[g] : (above_ge ? metric : above);
  end

  // Weights K_SEL+i grow towards the smaller selected entries.
  always_comb begin
    sum = '0;
    sel = '0;
    for (int i = 0; i < K_SEL; i++) begin
      sel = mode_q[1] ? arr[i] : arr[N_MOS-K_SEL+i];
      if (mode_q[0])
        sum = sum + SW'(K_SEL + i) * SW'(sel);
      else
        sum = sum + SW'(sel);
    end
  end

  assign quot = mode_q[0] ? sum / SW'(DIV_W) : sum / SW'(K_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= '0;
      out_q  <= '0;
      for (int i = 0; i < N_MOS; i++) arr[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          mode_q <= bus.mode;
          arr    <= ins;
          cnt    <= CTW'(1);
          state  <= ST_LOAD;
        end
        ST_LOAD: if (accept) begin
          arr <= ins;
          if (cnt == CTW'(N_MOS - 1)) begin
            cnt   <= '0;
            state <= ST_CALC;
          end else begin
            cnt <= cnt + CTW'(1);
          end
        end
        ST_CALC: begin
          out_q <= MW'(quot);
          state <= ST_OUT;
        end
        ST_OUT: if (bus.out_ready) begin
          for (int i = 0; i < N_MOS; i++) arr[i] <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smc_stream.sv
// Directed bench for smc_stream: mode table over a fixed frame, then gap, backpressure,
// mid-frame reset and v_gs=0 sequences. sat_cnt is checked when SMC_REGION_CNT_EN is defined.
module tb_smc_stream;

  typedef struct {
    logic [2:0] w;
    logic [2:0] v_gs;
    logic [2:0] v_ds;
  } beat_t;

  typedef struct {
    logic [1:0] mode;
    logic [8:0] exp_n;
    int         exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  beat_t beats [6];
  beat_t same7 [6];
  beat_t vgs0  [6];
  vec_t  tbl   [4];

`ifdef SMC_REGION_CNT_EN
  smc_stream_if #(.VW(3), .N_MOS(6)) bus ();
`else
  smc_stream_if #(.VW(3)) bus ();
`endif

  smc_stream #(.N_MOS(6), .K_SEL(3), .VW(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send_beat(input beat_t b, input logic [1:0] m);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.w        = b.w;
    bus.v_gs     = b.v_gs;
    bus.v_ds     = b.v_ds;
    bus.mode     = m;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0 for %0d cycles", t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input beat_t bt [6], input logic [1:0] m, input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      send_beat(bt[b], m);
      if (gaps && b < nb - 1) repeat (1 + b % 3) @(negedge clk);
    end
  endtask

  // Entered at the negedge of the CALC cycle; leaves at the first OUT negedge.
  task automatic check_result(input string tag, input int exp_n, input int exp_sat);
    check({tag, "_calc_vld"}, int'(bus.out_valid), 0);
    check({tag, "_calc_rdy"}, int'(bus.in_ready), 0);
    @(negedge clk);
    check({tag, "_out_vld"}, int'(bus.out_valid), 1);
    check({tag, "_out_rdy"}, int'(bus.in_ready), 0);
    check({tag, "_out_n"}, int'(bus.out_n), exp_n);
`ifdef SMC_REGION_CNT_EN
    check({tag, "_sat_cnt"}, int'(bus.sat_cnt), exp_sat);
`else
    if (exp_sat < 0) $display("note: negative sat expectation in %s", tag);
`endif
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_hs_vld"}, int'(bus.out_valid), 0);
    check({tag, "_hs_rdy"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    beats[0] = '{3'd3, 3'd4, 3'd5};
    beats[1] = '{3'd3, 3'd2, 3'd1};
    beats[2] = '{3'd6, 3'd4, 3'd1};
    beats[3] = '{3'd1, 3'd1, 3'd0};
    beats[4] = '{3'd7, 3'd7, 3'd7};
    beats[5] = '{3'd3, 3'd7, 3'd2};
    for (int i = 0; i < 6; i++) begin
      same7[i] = '{3'd7, 3'd7, 3'd7};
      vgs0[i]  = '{3'd7, 3'd0, 3'd3};
    end
    // gm: 6,2,4,0,28,4   Id: 9,1,10,0,84,20   four beats in saturation
    tbl[0] = '{2'b10, 9'd12, 4};
    tbl[1] = '{2'b00, 9'd2,  4};
    tbl[2] = '{2'b11, 9'd31, 4};
    tbl[3] = '{2'b01, 9'd2,  4};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'b00;
    bus.w         = '0;
    bus.v_gs      = '0;
    bus.v_ds      = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_n", int'(bus.out_n), 0);
`ifdef SMC_REGION_CNT_EN
    check("rst_sat_cnt", int'(bus.sat_cnt), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(bus.in_ready), 1);

    for (int v = 0; v < 4; v++) begin
      send_frame(beats, tbl[v].mode, 6, 1'b0);
      check_result($sformatf("tbl%0d", v), int'(tbl[v].exp_n), tbl[v].exp_sat);
      handshake($sformatf("tbl%0d", v));
    end

    // Gapped frame, then a 5-cycle stall with in_valid asserted and junk data.
    send_frame(same7, 2'b11, 6, 1'b1);
    check_result("gap", 84, 6);
    bus.in_valid = 1'b1;
    bus.w        = 3'd1;
    bus.v_gs     = 3'd0;
    bus.v_ds     = 3'd0;
    bus.mode     = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_vld", c), int'(bus.out_valid), 1);
      check($sformatf("hold%0d_n", c), int'(bus.out_n), 84);
      check($sformatf("hold%0d_rdy", c), int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("hold_release_rdy", int'(bus.in_ready), 1);
    send_frame(beats, 2'b10, 6, 1'b0);
    check_result("after_hold", 12, 4);
    handshake("after_hold");

    // Reset after three beats: everything clears, no partial result.
    send_frame(beats, 2'b10, 3, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_n", int'(bus.out_n), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_vld", int'(bus.out_valid), 0);
    send_frame(beats, 2'b11, 6, 1'b0);
    check_result("post_rst", 31, 4);
    handshake("post_rst");

    send_frame(vgs0, 2'b10, 6, 1'b0);
    check_result("vgs0", 0, 6);
    handshake("vgs0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
